// File: rtl/dbg_jtag_pkg.sv
// Shared definitions for the JTAG debug transport: default widths,
// virtual-IR channel encodings and the action-bit position helper.
package dbg_jtag_pkg;
    localparam int DEF_SR_W = 38;
    localparam int DEF_IR_W = 2;

    typedef enum logic [1:0] {
        CH_OCIMEM    = 2'd0,
        CH_TRACEMEM  = 2'd1,
        CH_BREAK     = 2'd2,
        CH_TRACECTRL = 2'd3
    } jtag_ch_e;

    // The top bit of the shift register selects take_action vs take_no_action.
    function automatic int act_bit(input int sr_w);
        return sr_w - 1;
    endfunction
endpackage

// File: rtl/dbg_sync_edge.sv
// Multi-flop synchroniser for a TCK-domain level, followed by a rising-edge
// detector that emits a single clk-cycle pulse.
module dbg_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic pulse
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    // Chain and history reset high so a level already high at release is not an edge.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~hist_q;
endmodule

// File: rtl/dbg_jtag_cmd_sync_fifo.sv
// System-clock half of the JTAG debug transport: synchronised update strobes,
// a first-word-fall-through command FIFO and per-channel action pulses.
module dbg_jtag_cmd_sync_fifo
    import dbg_jtag_pkg::*;
#(
    parameter int SR_W        = DEF_SR_W,
    parameter int IR_W        = DEF_IR_W,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    localparam int NCH        = 1 << IR_W,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            vs_udr,
    input  logic            vs_uir,
    input  logic [IR_W-1:0] ir_in,
    input  logic [SR_W-1:0] sr,
    input  logic            cmd_ready,
    input  logic            overflow_clr,
    output logic            cmd_valid,
    output logic [IR_W-1:0] cmd_ir,
    output logic [SR_W-1:0] jdo,
    output logic [AW:0]     level,
    output logic            overflow,
    output logic            ir_update,
    output logic [NCH-1:0]  take_action,
    output logic [NCH-1:0]  take_no_action
);
    localparam int ACT = act_bit(SR_W);

    logic udr_pulse, uir_pulse;

    dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
        .clk(clk), .reset_n(reset_n), .async_in(vs_udr), .pulse(udr_pulse)
    );

    dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
        .clk(clk), .reset_n(reset_n), .async_in(vs_uir), .pulse(uir_pulse)
    );

    logic [IR_W-1:0] mem_ir_q [DEPTH];
    logic [IR_W-1:0] mem_ir_d [DEPTH];
    logic [SR_W-1:0] mem_sr_q [DEPTH];
    logic [SR_W-1:0] mem_sr_d [DEPTH];
    logic [AW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic            overflow_q, overflow_d;
    logic            ir_update_q, ir_update_d;
    logic [NCH-1:0]  take_action_q, take_action_d;
    logic [NCH-1:0]  take_no_action_q, take_no_action_d;

    logic [AW:0]     level_w;
    logic            full, pop, wr_en, drop;
    logic [IR_W-1:0] head_ir;
    logic [SR_W-1:0] head_sr;

    assign level_w = wptr_q - rptr_q;
    assign full    = (level_w == (AW+1)'(DEPTH));
    assign head_ir = mem_ir_q[rptr_q[AW-1:0]];
    assign head_sr = mem_sr_q[rptr_q[AW-1:0]];
    assign pop     = (level_w != '0) & cmd_ready;
    // A pop in the same edge frees the slot, so a push on full is still accepted.
    assign wr_en   = udr_pulse & (~full | pop);
    assign drop    = udr_pulse & full & ~pop;

    always_comb begin
        mem_ir_d         = mem_ir_q;
        mem_sr_d         = mem_sr_q;
        wptr_d           = wptr_q;
        rptr_d           = rptr_q;
        overflow_d       = overflow_q;
        ir_update_d      = uir_pulse;
        take_action_d    = '0;
        take_no_action_d = '0;

        if (wr_en) begin
            mem_ir_d[wptr_q[AW-1:0]] = ir_in;
            mem_sr_d[wptr_q[AW-1:0]] = sr;
            wptr_d                   = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
            if (head_sr[ACT]) take_action_d[head_ir]    = 1'b1;
            else              take_no_action_d[head_ir] = 1'b1;
        end
        if (drop)              overflow_d = 1'b1;
        else if (overflow_clr) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_ir_q[i] <= '0;
                mem_sr_q[i] <= '0;
            end
            wptr_q           <= '0;
            rptr_q           <= '0;
            overflow_q       <= 1'b0;
            ir_update_q      <= 1'b0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
        end else begin
            mem_ir_q         <= mem_ir_d;
            mem_sr_q         <= mem_sr_d;
            wptr_q           <= wptr_d;
            rptr_q           <= rptr_d;
            overflow_q       <= overflow_d;
            ir_update_q      <= ir_update_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
        end
    end

    assign cmd_valid      = (level_w != '0);
    assign cmd_ir         = head_ir;
    assign jdo            = head_sr;
    assign level          = level_w;
    assign overflow       = overflow_q;
    assign ir_update      = ir_update_q;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
endmodule

// File: doc/dbg_jtag_cmd_sync_fifo.md
Name: dbg_jtag_cmd_sync_fifo

Overview:
- Generalised system-clock half of the Nios II JTAG debug transport.
- Synchronises the TCK-domain update strobes (vs_udr, vs_uir) into clk.
- On each update-DR, captures the shifted register and IR into a DEPTH-entry command FIFO, then issues per-channel take_action / take_no_action pulses as entries are consumed.
- Replaces fixed 38-bit / 2-bit-IR, unbuffered decode with parametrised widths, channel count, buffering and overflow reporting.

Parameters:
SR_W, 38, shift-register/command data width (>=2)
IR_W, 2, virtual-JTAG IR width; channel count NCH = 2**IR_W
DEPTH, 4, command FIFO depth, power of two, >=2
SYNC_STAGES, 2, synchroniser flops per strobe, >=2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
vs_udr  in  1  update-DR level from TCK domain (asynchronous)
vs_uir  in  1  update-IR level from TCK domain (asynchronous)
ir_in  in  IR_W  JTAG IR; stable while vs_udr/vs_uir are high and for SYNC_STAGES+2 clk after
sr  in  SR_W  JTAG shift register; same stability guarantee as ir_in
cmd_ready  in  1  consumer accepts head entry
overflow_clr  in  1  clears overflow sticky
cmd_valid  out  1  FIFO non-empty (first-word-fall-through)
cmd_ir  out  IR_W  head entry IR
jdo  out  SR_W  head entry data
level  out  $clog2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: update-DR dropped on full FIFO
ir_update  out  1  one-cycle pulse per synchronised update-IR
take_action  out  NCH  one-hot pulse: popped entry, channel cmd_ir, jdo[SR_W-1]=1
take_no_action  out  NCH  one-hot pulse: popped entry, channel cmd_ir, jdo[SR_W-1]=0

Behaviour:
- Reset (async assert, sync release): FIFO empty, cmd_valid=0, level=0, overflow=0, ir_update=0, take_action=0, take_no_action=0.
- Reset values for cmd_ir/jdo: 0.
- Reset values for synchroniser and edge-history flops: all 1. A strobe held high across reset release yields no pulse; a strobe held low yields no pulse.
- Strobe sync: SYNC_STAGES flops, then rising-edge detect (sync_out & ~hist), giving a one-cycle pulse.
- Latency: if vs_udr is first sampled 1 at edge E0, udr_pulse is high in the cycle after E(SYNC_STAGES-1). The FIFO write occurs at E(SYNC_STAGES). With the FIFO initially empty, cmd_valid=1 after E(SYNC_STAGES).
- udr_pulse pushes {ir_in, sr}.
- uir_pulse drives ir_update=1 for exactly the following cycle. It does not touch the FIFO.
- Pop: cmd_valid & cmd_ready at an edge. Head advances and level decrements.
- Push and pop in the same edge: level unchanged. This holds when full: the pop frees a slot, the push is accepted, and there is no overflow.
- Push on full without pop: entry dropped, contents unchanged, overflow<=1.
- overflow_clr clears overflow. If a new drop occurs in the same cycle as clear, set wins.
- cmd_ready with cmd_valid=0: ignored. Pop on empty never corrupts pointers.
- Action pulses are registered. For a pop at edge Ek, exactly one bit of take_action or take_no_action is high for the cycle after Ek.
  - Bit index = popped cmd_ir.
  - Polarity is selected by the popped jdo[SR_W-1].
  - With no pop, both vectors are 0.
- Pointers: $clog2(DEPTH)-bit indices plus an extra wrap bit. Wrap-around is natural modulo DEPTH.
- level = wptr - rptr, width $clog2(DEPTH)+1.
- Reset mid-operation: pending entries lost, pulses in flight suppressed, overflow cleared.

Decomposition:
- Shared package dbg_jtag_pkg:
  - default SR_W=38, IR_W=2
  - channel encodings CH_OCIMEM=0, CH_TRACEMEM=1, CH_BREAK=2, CH_TRACECTRL=3
  - action-bit index function (SR_W-1)
- Sub-module dbg_sync_edge (parameter SYNC_STAGES, reset-to-1 chain + rising-edge pulse), instantiated for vs_udr and vs_uir.
- FIFO storage and decode stay in the top.

Test Plan:
1. Single update: ir_in=2, sr[37]=1, sr[31:0]=0x1234_5678, vs_udr high 10 clk. Required: cmd_valid rises 3 edges after first sample (SYNC_STAGES=2); cmd_ir=2; jdo[31:0]=0x12345678. Then cmd_ready=1 one cycle: take_action=4'b0100 for one cycle; level returns to 0.
2. No-action decode: ir_in=0, sr[37]=0, one update, popped. Required: take_no_action=4'b0001 and take_action=0.
3. Overflow: cmd_ready=0, 5 updates with distinct sr. Required: level=4, overflow=1. Pops return entries 1-4 in order; the 5th is absent.
4. Full with simultaneous push and pop: level=4, udr_pulse coincides with pop. Required: level stays 4, overflow stays 0, new entry appears last.
5. Clear vs set: overflow=1, overflow_clr asserted in the same cycle as another drop. Required: overflow stays 1. Clear alone gives 0 next cycle.
6. Reset behaviour: vs_udr held high through reset release. Required: no push, cmd_valid=0. Separately, assert reset_n=0 with 3 queued entries: level=0 and all pulses 0 immediately. Also vs_uir toggle gives exactly one ir_update pulse with level unchanged.
